// File: rtl/arb8_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : arb8_rr_if
// Description : Request/beat/grant bundle between 8 requesters, the arbiter
//               and the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface arb8_rr_if;
    logic [7:0] req;
    logic [7:0] last;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       out_last;
    logic       timeout;

    modport master (
        input  req, last, out_ready,
        output sel, grant, out_valid, out_last, timeout
    );

    modport slave (
        output req, last, out_ready,
        input  sel, grant, out_valid, out_last, timeout
    );
endinterface
`default_nettype wire

// File: rtl/arb8_rr.sv
`default_nettype none
// ============================================================================
// Module      : arb8_rr
// Description : 8-way packet-locked round-robin arbiter with a per-grant
//               beat limit that forces release and pulses timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module arb8_rr #(
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arb8_rr_if.master     bus
);

    localparam logic       c_st_idle   = 1'b0;
    localparam logic       c_st_locked = 1'b1;
    localparam logic [7:0] c_max_beats = 8'(MAX_BEATS);

    logic       r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic [7:0] r_beats;
    logic       r_timeout;

    logic       w_state_nxt;
    logic [2:0] w_ptr_nxt;
    logic [2:0] w_sel_nxt;
    logic [7:0] w_beats_nxt;
    logic       w_timeout_nxt;

    logic [2:0] w_winner;
    logic [7:0] w_beats_inc;
    logic       w_locked;
    logic       w_out_valid;
    logic       w_out_last;
    logic       w_accept;

    // Scan from the far end so the closest set bit to ptr wins last.
    always_comb begin
        w_winner = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[r_ptr + 3'(i)]) begin
                w_winner = r_ptr + 3'(i);
            end
        end
    end

    assign w_locked    = (r_state == c_st_locked);
    assign w_out_valid = w_locked & bus.req[r_sel];
    assign w_out_last  = w_out_valid & bus.last[r_sel];
    assign w_accept    = w_out_valid & bus.out_ready;
    assign w_beats_inc = r_beats + 8'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_beats_nxt   = r_beats;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.req != 8'h00) begin
                    w_sel_nxt   = w_winner;
                    w_beats_nxt = 8'd0;
                    w_state_nxt = c_st_locked;
                end
            end
            default: begin
                if (w_accept) begin
                    // last wins over the beat limit, so no timeout when both hit
                    if (bus.last[r_sel]) begin
                        w_state_nxt = c_st_idle;
                        w_ptr_nxt   = r_sel + 3'd1;
                    end else if (w_beats_inc == c_max_beats) begin
                        w_state_nxt   = c_st_idle;
                        w_ptr_nxt     = r_sel + 3'd1;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_beats_nxt = w_beats_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_ptr     <= 3'd0;
            r_sel     <= 3'd0;
            r_beats   <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_beats   <= w_beats_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.grant     = w_locked ? (8'b1 << r_sel) : 8'h00;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb8_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb8_rr
// Description : Directed self-checking bench for arb8_rr (MAX_BEATS = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb8_rr;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb8_rr_if bus ();

    arb8_rr #(.MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.last      = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.req       = 8'hFF;
        bus.last      = 8'hFF;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL rst_grant got %h exp 00", bus.grant); end
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", bus.sel); end
        checks++; if ({bus.out_valid, bus.out_last, bus.timeout} !== 3'b000) begin errors++; $display("FAIL rst_outs got %b exp 000", {bus.out_valid, bus.out_last, bus.timeout}); end
        rst_n   = 1'b1;
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_two_req;
        do_reset();
        bus.req       = 8'h90;
        bus.last      = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.out_valid); end
        tick();
        checks++; if (bus.sel !== 3'd4 || bus.grant !== 8'h10) begin errors++; $display("FAIL two_first got sel %0d grant %h exp sel 4 grant 10", bus.sel, bus.grant); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin errors++; $display("FAIL two_outs got %b%b exp 11", bus.out_valid, bus.out_last); end
        tick();
        checks++; if (bus.grant !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL two_bubble got grant %h valid %b exp 00 0", bus.grant, bus.out_valid); end
        tick();
        checks++; if (bus.sel !== 3'd7 || bus.grant !== 8'h80) begin errors++; $display("FAIL two_second got sel %0d grant %h exp sel 7 grant 80", bus.sel, bus.grant); end
        tick();
        tick();
        checks++; if (bus.sel !== 3'd4 || bus.grant !== 8'h10) begin errors++; $display("FAIL two_third got sel %0d grant %h exp sel 4 grant 10", bus.sel, bus.grant); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_all_ff;
        do_reset();
        bus.req       = 8'hFF;
        bus.last      = 8'hFF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++; if (bus.sel !== k[2:0] || bus.grant !== (8'h01 << k[2:0])) begin errors++; $display("FAIL rr_grant_%0d got sel %0d grant %h exp sel %0d", k, bus.sel, bus.grant, k[2:0]); end
            tick();
            checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL rr_bubble_%0d got %h exp 00", k, bus.grant); end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_ready_toggle;
        do_reset();
        bus.req       = 8'h04;
        bus.last      = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        // ready pattern 1,0,1,0,1; beat 3 is presented during the last two cycles
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = (c % 2 == 0);
            bus.last      = (c >= 3) ? 8'h04 : 8'h00;
            #1;
            checks++; if (bus.grant !== 8'h04 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL tog_hold_%0d got grant %h valid %b exp 04 1", c, bus.grant, bus.out_valid); end
            checks++; if (bus.out_last !== (c >= 3)) begin errors++; $display("FAIL tog_last_%0d got %b exp %b", c, bus.out_last, (c >= 3)); end
            tick();
        end
        checks++; if (bus.grant !== 8'h00 || bus.timeout !== 1'b0) begin errors++; $display("FAIL tog_release got grant %h timeout %b exp 00 0", bus.grant, bus.timeout); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        bus.req       = 8'h20;
        bus.last      = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            checks++; if (bus.grant !== 8'h20 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_beat_%0d got grant %h timeout %b exp 20 0", b, bus.grant, bus.timeout); end
            tick();
        end
        checks++; if (bus.timeout !== 1'b1 || bus.grant !== 8'h00) begin errors++; $display("FAIL to_pulse got timeout %b grant %h exp 1 00", bus.timeout, bus.grant); end
        bus.req = 8'h61;
        tick();
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_width got %b exp 0", bus.timeout); end
        checks++; if (bus.sel !== 3'd6) begin errors++; $display("FAIL to_next got sel %0d exp 6", bus.sel); end
        // limit and last coincide on beat 4: normal release
        bus.req = 8'h40;
        for (int b = 0; b < 4; b++) begin
            bus.last = (b == 3) ? 8'h40 : 8'h00;
            tick();
        end
        checks++; if (bus.grant !== 8'h00 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_coincide got grant %h timeout %b exp 00 0", bus.grant, bus.timeout); end
        bus.req  = 8'h00;
        bus.last = 8'h00;
        tick();
    endtask

    task automatic test_drop;
        do_reset();
        bus.req       = 8'h0A;
        bus.last      = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.sel !== 3'd1) begin errors++; $display("FAIL drop_win got sel %0d exp 1", bus.sel); end
        tick();
        bus.req = 8'h08;
        for (int d = 0; d < 2; d++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.grant !== 8'h02) begin errors++; $display("FAIL drop_hold_%0d got valid %b grant %h exp 0 02", d, bus.out_valid, bus.grant); end
            tick();
        end
        bus.req = 8'h0A;
        tick();
        checks++; if (bus.grant !== 8'h02 || bus.timeout !== 1'b0) begin errors++; $display("FAIL drop_count got grant %h timeout %b exp 02 0", bus.grant, bus.timeout); end
        bus.last = 8'h02;
        tick();
        checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL drop_release got %h exp 00", bus.grant); end
        bus.last = 8'h00;
        tick();
        checks++; if (bus.sel !== 3'd3) begin errors++; $display("FAIL drop_next got sel %0d exp 3", bus.sel); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_mid_reset;
        do_reset();
        bus.req       = 8'h40;
        bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.sel !== 3'd6 || bus.grant !== 8'h40) begin errors++; $display("FAIL mr_lock got sel %0d grant %h exp 6 40", bus.sel, bus.grant); end
        rst_n   = 1'b0;
        bus.req = 8'h41;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.grant !== 8'h00 || bus.out_valid !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL mr_clear got grant %h valid %b timeout %b exp 00 0 0", bus.grant, bus.out_valid, bus.timeout); end
        tick();
        checks++; if (bus.sel !== 3'd0 || bus.grant !== 8'h01) begin errors++; $display("FAIL mr_next got sel %0d grant %h exp 0 01", bus.sel, bus.grant); end
        bus.req = 8'h00;
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.last      = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_two_req();
        test_all_ff();
        test_ready_toggle();
        test_timeout();
        test_drop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb8_rr.md
ARB8_RR -- requirements
Module: arb8_rr

Interface -- parameters (name, default, meaning)
REQ-001 SHALL have parameter MAX_BEATS, default 16: the largest number of accepted beats in one grant before the grant is forcibly released; legal range 1..255.

Interface -- ports (name  direction  width  meaning)
REQ-002 SHALL have clk  input  1  the only clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have req  input  8  per-requester valid; bit i means requester i is presenting a beat.
REQ-005 SHALL have last  input  8  per-requester end-of-packet flag; bit i is meaningful only while req[i]=1.
REQ-006 SHALL have out_ready  input  1  the downstream consumer accepts the current beat.
REQ-007 SHALL have sel  output  3  the index of the granted requester; it drives the 3-bit select of the downstream 8:1 mux.
REQ-008 SHALL have grant  output  8  one-hot grant (bit sel) while LOCKED, else all zero.
REQ-009 SHALL have out_valid  output  1  the selected beat is valid toward the consumer.
REQ-010 SHALL have out_last  output  1  the selected beat is the final beat of its packet.
REQ-011 SHALL have timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-012 SHALL implement the two-state FSM IDLE and LOCKED.
REQ-013 SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ... ptr+7, taken mod 8.
REQ-014 SHALL, in IDLE with req!=0, register the first set req bit in search order into sel, set grant to one-hot(sel), and enter LOCKED on the next edge (arbitration latency of 1 cycle).
REQ-015 SHALL remain in IDLE with sel unchanged when req==0 in IDLE.
REQ-016 SHALL hold sel and grant stable throughout LOCKED, whatever the other req bits do.
REQ-017 SHALL drive out_valid = LOCKED && req[sel], combinationally.
REQ-018 SHALL drive out_last = out_valid && last[sel], combinationally.
REQ-019 SHALL count a beat only when out_valid && out_ready in LOCKED; the 8-bit beat counter clears on every grant.
REQ-020 SHALL, when a beat is counted with last[sel]=1, go to IDLE on that edge, clear grant, and set ptr=sel+1 mod 8.
REQ-021 SHALL, when a beat is counted and it is beat number MAX_BEATS without last, go to IDLE, set ptr=sel+1 mod 8, and pulse timeout high for exactly the following cycle.
REQ-022 SHALL let last take priority when the last beat and the MAX_BEATS-th beat coincide: normal release, no timeout.
REQ-023 SHALL, when the granted requester drops req mid-packet, drive out_valid low, keep the grant held, and not advance the beat count.
REQ-024 SHALL NOT arbitrate in the cycle of a release; the earliest new grant is 1 idle cycle after the release edge, so the minimum gap between packets is 1 bubble.
REQ-025 SHALL keep out_valid 0 whenever out_ready is ignored (IDLE); out_ready SHALL have no effect in IDLE.
REQ-026 SHALL skip a requester that has just been served when any other requester is requesting (fairness): each of 8 continuously requesting sources is served once per 8 grants.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, put the FSM in IDLE and set ptr=0, sel=0, grant=0, beat count=0, timeout=0; out_valid=0 and out_last=0 follow from this.
REQ-028 SHALL treat a reset asserted mid-packet as dropping the packet entirely, with no timeout pulse.
REQ-029 SHALL respond to rst_n only at a clock edge; there is no asynchronous path from rst_n to any output.

Verification
REQ-030 SHALL cover: after reset, req=8'h90 with all beats last=1 and out_ready=1 -> sel=4 one cycle later, then sel=7, then sel=4.
REQ-031 SHALL cover: req=8'hFF held, every beat last, out_ready=1 -> sel sequence 0,1,...,7,0 with one IDLE cycle between grants.
REQ-032 SHALL cover: requester 2 sends a 3-beat packet while out_ready toggles 1,0,1,0,1 -> sel stays 2, exactly 3 counted beats, out_last only on beat 3, then release.
REQ-033 SHALL cover: MAX_BEATS=4, requester 5 never asserts last -> timeout=1 for one cycle after the 4th beat, next search begins at 6.
REQ-034 SHALL cover: requester 1 deasserts req for 2 cycles mid-packet while req[3]=1 -> out_valid=0, grant stays 8'h02, no switch to 3.
REQ-035 SHALL cover: rst_n=0 for one cycle in LOCKED with sel=6 -> the next cycle has grant=0, out_valid=0, ptr=0, and with req=8'h41 the next winner is 0.
